// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU MEM stage vs external master.
// Optional DM_ARB_RR_EN selects round-robin instead of starvation-guarded priority.
module dm_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [3:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_wr,
    input  logic [3:0]    ext_be,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic [DW-1:0] ext_rdata,
    output logic          dm_wr,
    output logic [3:0]    dm_be,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    input  logic [DW-1:0] dm_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;

    state_t        state_q, state_d;
    logic          own_q, own_d;
    logic          wr_q, wr_d;
    logic [3:0]    be_q, be_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ext_ack_q, ext_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ext_rdata_q, ext_rdata_d;

    logic any_req;
    logic grant;
    logic pick_ext;
    logic acc;

`ifdef DM_ARB_RR_EN
    // rr_last names the side favoured on the next tie; it resets to EXT
    logic rr_last_q, rr_last_d;
`else
    logic [3:0] starve_q, starve_d;
`endif

    assign any_req = cpu_req | ext_req;
    assign grant   = (state_q != S_ACCESS) & any_req;

    // Pick the winner among the current requesters
    always_comb begin
        pick_ext = ext_req;
        if (cpu_req && ext_req) begin
`ifdef DM_ARB_RR_EN
            pick_ext = (rr_last_q == OWN_EXT);
`else
            pick_ext = (starve_q == 4'(STARVE_LIMIT));
`endif
        end
    end

`ifdef DM_ARB_RR_EN
    // Favour the loser of each grant on the next tie
    always_comb begin
        rr_last_d = rr_last_q;
        if (grant) begin
            rr_last_d = pick_ext ? OWN_CPU : OWN_EXT;
        end
    end
`else
    // Count CPU wins that pass over a waiting external master
    always_comb begin
        starve_d = starve_q;
        if (!ext_req) begin
            starve_d = 4'd0;
        end else if (grant) begin
            if (pick_ext) begin
                starve_d = 4'd0;
            end else if (starve_q != 4'hF) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end
`endif

    // Next-state, request latching and response capture
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        wr_d        = wr_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_ack_d   = 1'b0;
        ext_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ext_rdata_d = ext_rdata_q;
        unique case (state_q)
            S_IDLE, S_RESP: begin
                if (any_req) begin
                    state_d = S_ACCESS;
                    own_d   = pick_ext;
                    if (pick_ext) begin
                        wr_d    = ext_wr;
                        be_d    = ext_be;
                        addr_d  = ext_addr;
                        wdata_d = ext_wdata;
                    end else begin
                        wr_d    = cpu_wr;
                        be_d    = cpu_be;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (own_q == OWN_EXT) begin
                    ext_ack_d   = 1'b1;
                    ext_rdata_d = dm_dout;
                end else begin
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = dm_dout;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            own_q       <= OWN_CPU;
            wr_q        <= 1'b0;
            be_q        <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
`ifdef DM_ARB_RR_EN
            rr_last_q   <= OWN_EXT;
`else
            starve_q    <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            wr_q        <= wr_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ext_ack_q   <= ext_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
`ifdef DM_ARB_RR_EN
            rr_last_q   <= rr_last_d;
`else
            starve_q    <= starve_d;
`endif
        end
    end

    // A reset arriving mid-access must not commit the store
    assign acc       = (state_q == S_ACCESS) & rst_n;
    assign dm_wr     = acc & wr_q;
    assign dm_be     = acc ? be_q : 4'd0;
    assign dm_addr   = acc ? addr_q : '0;
    assign dm_din    = acc ? wdata_q : '0;
    assign cpu_ack   = cpu_ack_q;
    assign ext_ack   = ext_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule
